// File: rtl/chan_sample_bank.sv
`default_nettype none
// ============================================================================
//  Module   : chan_sample_bank
//  Purpose  : Multi-channel registered sampler. NUM_CH words of WIDTH bits
//             travel through a DEPTH-stage pipeline (output register
//             included); the output stage applies a per-beat mode (PASS,
//             STICKY-OR, EDGE detect, HOLD) and raises per-channel nonzero
//             events that feed saturating counters.
//  Ports    : clk      - rising-edge clock
//             reset    - asynchronous clear, active low
//             soft_clr - synchronous clear, active high (beats en)
//             en       - pipeline advance; 0 stalls and drops the input beat
//             mode     - 00 PASS, 01 STICKY, 10 EDGE, 11 HOLD
//             a        - channel data, channel c = a[c*WIDTH +: WIDTH]
//             a_valid  - a carries a beat this cycle
//             q        - registered channel results, same packing as a
//             q_valid  - q was updated by a beat on the last edge
//             evt      - per-channel pulse: value written to q_c nonzero
//             cnt      - per-channel saturating event counts
//  Revision : 1.0 - initial release
// ============================================================================
module chan_sample_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    soft_clr,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [NUM_CH*WIDTH-1:0] a,
    input  logic                    a_valid,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic                    q_valid,
    output logic [NUM_CH-1:0]       evt,
    output logic [NUM_CH*CNT_W-1:0] cnt
);

    localparam int               c_dw        = NUM_CH * WIDTH;
    localparam logic [1:0]       c_mode_pass = 2'b00;
    localparam logic [1:0]       c_mode_stky = 2'b01;
    localparam logic [1:0]       c_mode_edge = 2'b10;
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    // Beat arriving at the output stage
    logic [c_dw-1:0]         w_arr_data;
    logic                    w_arr_vld;

    // Output-stage registers
    logic [c_dw-1:0]         r_q;
    logic [c_dw-1:0]         r_prev;
    logic                    r_qv;
    logic [NUM_CH-1:0]       r_evt;
    logic [NUM_CH*CNT_W-1:0] r_cnt;

    // Next-state values used when a valid beat arrives
    logic [c_dw-1:0]         w_q_next;
    logic [NUM_CH-1:0]       w_evt_next;
    logic [NUM_CH*CNT_W-1:0] w_cnt_next;

    // ------------------------------------------------------------------
    // Pre-output pipeline: DEPTH-1 stages. With DEPTH=1 the output stage
    // consumes the input directly.
    // ------------------------------------------------------------------
    generate
        if (DEPTH == 1) begin : g_direct
            assign w_arr_data = a;
            assign w_arr_vld  = a_valid;
        end else begin : g_pipe
            logic [c_dw-1:0] r_data [DEPTH-1];
            logic [DEPTH-2:0] r_vld;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < DEPTH-1; k++) r_data[k] <= '0;
                    r_vld <= '0;
                end else if (soft_clr) begin
                    for (int k = 0; k < DEPTH-1; k++) r_data[k] <= '0;
                    r_vld <= '0;
                end else if (en) begin
                    r_data[0] <= a;
                    r_vld[0]  <= a_valid;
                    for (int k = 1; k < DEPTH-1; k++) begin
                        r_data[k] <= r_data[k-1];
                        r_vld[k]  <= r_vld[k-1];
                    end
                end
            end

            assign w_arr_data = r_data[DEPTH-2];
            assign w_arr_vld  = r_vld[DEPTH-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output-stage computation per channel. HOLD keeps q_c and still tests
    // the retained value for the event.
    // ------------------------------------------------------------------
    always_comb begin
        w_q_next   = r_q;
        w_evt_next = '0;
        w_cnt_next = r_cnt;
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode)
                c_mode_pass: w_q_next[c*WIDTH +: WIDTH] = w_arr_data[c*WIDTH +: WIDTH];
                c_mode_stky: w_q_next[c*WIDTH +: WIDTH] = r_q[c*WIDTH +: WIDTH]
                                                        | w_arr_data[c*WIDTH +: WIDTH];
                c_mode_edge: w_q_next[c*WIDTH +: WIDTH] = w_arr_data[c*WIDTH +: WIDTH]
                                                        & ~r_prev[c*WIDTH +: WIDTH];
                default:     w_q_next[c*WIDTH +: WIDTH] = r_q[c*WIDTH +: WIDTH];
            endcase
            w_evt_next[c] = |w_q_next[c*WIDTH +: WIDTH];
            if (w_evt_next[c] && (r_cnt[c*CNT_W +: CNT_W] != c_cnt_max)) begin
                w_cnt_next[c*CNT_W +: CNT_W] = r_cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_prev <= '0;
            r_qv   <= 1'b0;
            r_evt  <= '0;
            r_cnt  <= '0;
        end else if (soft_clr) begin
            r_q    <= '0;
            r_prev <= '0;
            r_qv   <= 1'b0;
            r_evt  <= '0;
            r_cnt  <= '0;
        end else if (!en) begin
            r_qv  <= 1'b0;
            r_evt <= '0;
        end else if (w_arr_vld) begin
            r_q    <= w_q_next;
            r_prev <= w_arr_data;   // tracked in every mode so EDGE starts clean
            r_qv   <= 1'b1;
            r_evt  <= w_evt_next;
            r_cnt  <= w_cnt_next;
        end else begin
            r_qv  <= 1'b0;
            r_evt <= '0;
        end
    end

    assign q       = r_q;
    assign q_valid = r_qv;
    assign evt     = r_evt;
    assign cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_chan_sample_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chan_sample_bank
//  Purpose  : Directed self-checking bench for chan_sample_bank with
//             NUM_CH=4, WIDTH=8, DEPTH=2, CNT_W=4. Inputs change 1 time unit
//             after a rising edge; outputs are checked at the same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chan_sample_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    reset;
    logic                    soft_clr;
    logic                    en;
    logic [1:0]              mode;
    logic [NUM_CH*WIDTH-1:0] a;
    logic                    a_valid;
    logic [NUM_CH*WIDTH-1:0] q;
    logic                    q_valid;
    logic [NUM_CH-1:0]       evt;
    logic [NUM_CH*CNT_W-1:0] cnt;

    int n_chk  = 0;
    int n_pass = 0;

    chan_sample_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .soft_clr (soft_clr),
        .en       (en),
        .mode     (mode),
        .a        (a),
        .a_valid  (a_valid),
        .q        (q),
        .q_valid  (q_valid),
        .evt      (evt),
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic v);
        a       = d;
        a_valid = v;
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        soft_clr = 1'b0;
        en       = 1'b1;
        mode     = 2'b00;
        a        = '0;
        a_valid  = 1'b0;

        // Reset state
        #12;
        check("rst_q",    64'(q),       64'h0);
        check("rst_qv",   64'(q_valid), 64'h0);
        check("rst_evt",  64'(evt),     64'h0);
        check("rst_cnt",  64'(cnt),     64'h0);
        #10 reset = 1'b1;     // released between edges
        tick();

        // Latency and PASS
        beat(32'h04030201, 1'b1);
        check("pass_t0_qv", 64'(q_valid), 64'h0);
        beat(32'h0, 1'b0);
        check("pass_q",   64'(q),       64'h04030201);
        check("pass_qv",  64'(q_valid), 64'h1);
        check("pass_evt", 64'(evt),     64'hF);
        check("pass_cnt", 64'(cnt),     64'h1111);
        tick();
        check("pass_qv_drop", 64'(q_valid), 64'h0);

        // STICKY accumulation on channel 0 (other channels keep nonzero q)
        mode = 2'b01;
        beat(32'h00000001, 1'b1);
        beat(32'h00000002, 1'b1);
        check("stky_1", 64'(q[7:0]), 64'h01);
        beat(32'h00000080, 1'b1);
        check("stky_2", 64'(q[7:0]), 64'h03);
        beat(32'h0, 1'b0);
        check("stky_3",     64'(q[7:0]), 64'h83);
        check("stky_3_evt", 64'(evt),    64'hF);
        mode = 2'b00;
        beat(32'h0, 1'b1);
        beat(32'h0, 1'b0);
        check("stky_pass0_q",   64'(q),   64'h0);
        check("stky_pass0_evt", 64'(evt), 64'h0);
        check("stky_cnt",       64'(cnt), 64'h4444);

        // EDGE detection on channel 1
        mode = 2'b10;
        beat(32'h00000F00, 1'b1);
        beat(32'h00000F00, 1'b1);
        check("edge_1",     64'(q[15:8]), 64'h0F);
        check("edge_1_evt", 64'(evt),     64'h2);
        beat(32'h0000FF00, 1'b1);
        check("edge_2",     64'(q[15:8]), 64'h00);
        check("edge_2_evt", 64'(evt),     64'h0);
        beat(32'h0, 1'b0);
        check("edge_3",     64'(q[15:8]), 64'hF0);
        check("edge_3_evt", 64'(evt),     64'h2);
        check("edge_cnt",   64'(cnt),     64'h4464);

        // Stall and dropped beat
        mode = 2'b00;
        tick();
        beat(32'h11223344, 1'b1);            // edge t0
        en = 1'b0;
        beat(32'h55667788, 1'b1);            // edge t0+1, stalled
        check("stall_qv", 64'(q_valid), 64'h0);
        check("stall_q",  64'(q),       64'h0000F000);
        en = 1'b1;
        beat(32'h0, 1'b0);                   // edge t0+2
        check("stall_qA",  64'(q),       64'h11223344);
        check("stall_qvA", 64'(q_valid), 64'h1);
        tick();
        check("stall_noB",  64'(q),       64'h11223344);
        check("stall_qv0",  64'(q_valid), 64'h0);
        check("stall_cnt",  64'(cnt),     64'h5575);

        // Counter saturation on channel 2
        for (int i = 0; i < 20; i++) beat(32'h00010000, 1'b1);
        beat(32'h0, 1'b0);
        tick();
        check("sat_cnt", 64'(cnt), 64'h5F75);

        // soft_clr with en=0 and a beat in flight
        beat(32'h01010101, 1'b1);            // in flight in stage 1
        soft_clr = 1'b1;
        en       = 1'b0;
        beat(32'h0F0F0F0F, 1'b1);
        check("sclr_q",   64'(q),       64'h0);
        check("sclr_cnt", 64'(cnt),     64'h0);
        check("sclr_qv",  64'(q_valid), 64'h0);
        check("sclr_evt", 64'(evt),     64'h0);
        soft_clr = 1'b0;
        en       = 1'b1;
        beat(32'h0, 1'b0);
        check("sclr_noemerge_q",  64'(q),       64'h0);
        check("sclr_noemerge_qv", 64'(q_valid), 64'h0);

        // Asynchronous reset with a full pipeline
        beat(32'h0A0B0C0D, 1'b1);
        beat(32'h01020304, 1'b1);
        check("arst_pre_q",   64'(q),   64'h0A0B0C0D);
        check("arst_pre_cnt", 64'(cnt), 64'h1111);
        a_valid = 1'b0;
        a       = '0;
        #2 reset = 1'b0;
        #1;
        check("arst_q",   64'(q),       64'h0);
        check("arst_qv",  64'(q_valid), 64'h0);
        check("arst_evt", 64'(evt),     64'h0);
        check("arst_cnt", 64'(cnt),     64'h0);
        #2 reset = 1'b1;
        tick();
        check("arst_post_qv1", 64'(q_valid), 64'h0);
        tick();
        check("arst_post_q",   64'(q),       64'h0);
        check("arst_post_qv2", 64'(q_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
